// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// One quotient bit per cycle in CALC; signs are fixed up in a single FIX cycle.

module add_and_subtract #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic             is_rem;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             cout;
  logic             diff_unused;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign div_zero  = (b == '0);
  assign ovf       = signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign special   = div_zero | ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? a : '1;
    end else if (ovf) begin
      special_res = op[1] ? '0 : a;
    end
  end

  // dvd doubles as the quotient: its MSB feeds the remainder while quotient bits enter at the LSB.
  assign shifted = {rem, dvd[WIDTH-1]};

  add_and_subtract #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a   (shifted),
    .b   ({1'b0, dvs}),
    .sub (1'b1),
    .sum (diff),
    .cout(cout)
  );

  // A kept difference is always below the divisor, so its top bit is zero.
  assign diff_unused = diff[WIDTH];
  assign rem_nxt     = cout ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_fix       = neg_q ? -dvd : dvd;
  assign r_fix       = neg_r ? -rem : rem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !special) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
            end else begin
              dvd    <= a_mag;
              dvs    <= b_mag;
              rem    <= '0;
              cnt    <= '0;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              is_rem <= op[1];
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], cout};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          result <= is_rem ? r_fix : q_fix;
          done   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
// Directed vectors, hand-built corner sequences and random operations against an arithmetic model.

module tb_iterative_divider;

  localparam int W = 32;
  localparam int NORM_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  iterative_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
    case (o)
      2'd0:    return 32'(sx / sy);
      2'd1:    return x / y;
      2'd2:    return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (y == 0) return 0;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return NORM_LAT;
  endfunction

  // lat counts edges after the start edge until done is seen; busy_cnt counts busy cycles before done.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] res, output int lat, output int busy_cnt);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy) busy_cnt += 1000;
    res = result;
  endtask

  task automatic run_checked(input string name, input logic [1:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp, input int exp_lat,
                             input bit check_tail);
    logic [W-1:0] res;
    int lat;
    int bc;
    do_op(o, x, y, res, lat, bc);
    chk({name, " result"}, res, exp);
    chk({name, " latency"}, W'(lat), W'(exp_lat));
    chk({name, " busy cycles"}, W'(bc), W'(exp_lat == 0 ? 0 : NORM_LAT));
    if (check_tail) begin
      @(posedge clk);
      #1;
      chk({name, " done width"}, W'(done), W'(0));
      chk({name, " result held"}, result, exp);
    end
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] prev;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   ro;
    int lat;
    int bc;
    int ndone;

    vecs[0]  = '{"divu_100_7",  2'd1, 32'd100,        32'd7,          32'd14,         NORM_LAT};
    vecs[1]  = '{"remu_100_7",  2'd3, 32'd100,        32'd7,          32'd2,          NORM_LAT};
    vecs[2]  = '{"div_m7_2",    2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM_LAT};
    vecs[3]  = '{"rem_m7_2",    2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM_LAT};
    vecs[4]  = '{"div_7_m2",    2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORM_LAT};
    vecs[5]  = '{"rem_7_m2",    2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          NORM_LAT};
    vecs[6]  = '{"div_5_0",     2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[7]  = '{"remu_5_0",    2'd3, 32'd5,          32'd0,          32'd5,          0};
    vecs[8]  = '{"rem_min_0",   2'd2, 32'h8000_0000,  32'd0,          32'h8000_0000,  0};
    vecs[9]  = '{"div_ovf",     2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[10] = '{"rem_ovf",     2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    vecs[11] = '{"divu_ovfops", 2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NORM_LAT};
    vecs[12] = '{"rem_0_m5",    2'd2, 32'd0,          32'hFFFF_FFFB,  32'd0,          NORM_LAT};
    vecs[13] = '{"divu_max_1",  2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NORM_LAT};
    vecs[14] = '{"remu_max_16", 2'd3, 32'hFFFF_FFFF,  32'd16,         32'd15,         NORM_LAT};

    rst = 1'b1;
    start = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset result", result, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      run_checked(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
    end

    // Starts and operand changes while busy must not disturb the running divide.
    op = 2'd1;
    a = 32'd1000;
    b = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    prev = result;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 3) begin
        start = 1'b1;
        op = 2'd0;
        a = 32'd7;
        b = 32'd3;
      end else if (lat == 4) begin
        start = 1'b0;
      end else if (lat > 4) begin
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
      end
      if (lat == 20) chk("capture result stable while busy", result, prev);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("capture result", result, 32'd100);
    chk("capture latency", W'(lat), W'(NORM_LAT));
    // Back-to-back: new start issued while done is high.
    run_checked("back_to_back", 2'd1, 32'd81, 32'd9, 32'd9, NORM_LAT, 1'b1);

    // Reset in the middle of CALC aborts without a done pulse.
    op = 2'd0;
    a = 32'hFFFF_FF9C;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset busy", W'(busy), W'(0));
    chk("midreset done", W'(done), W'(0));
    chk("midreset result", result, '0);
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midreset no done pulse", W'(ndone), W'(0));
    run_checked("after_reset_divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, NORM_LAT, 1'b1);

    // Simultaneous start and reset: reset wins.
    rst = 1'b1;
    start = 1'b1;
    op = 2'd1;
    a = 32'd50;
    b = 32'd5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("start_with_rst busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    chk("start_with_rst done", W'(done), W'(0));
    chk("start_with_rst idle", W'(busy), W'(0));

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = W'($urandom_range(1, 20));
        3: ra = 32'h8000_0000;
        4: begin
          rb = W'($urandom_range(1, 1000));
          ra = W'($urandom_range(0, 100000));
        end
        default: begin
        end
      endcase
      do_op(ro, ra, rb, res, lat, bc);
      chk($sformatf("rand%0d op%0d %h/%h result", i, ro, ra, rb), res, ref_model(ro, ra, rb));
      chk($sformatf("rand%0d latency", i), W'(lat), W'(ref_lat(ro, ra, rb)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions in the EX stage. It is the sequential counterpart to the combinational `add_and_subtract` datapath and uses one `add_and_subtract #(WIDTH+1)` instance in subtract mode per iteration step. The EX stage stalls on `busy` and captures `result` on `done`.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be ≥ 2.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  2: funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `a`  in  WIDTH: dividend, captured on the accepted start.
- `b`  in  WIDTH: divisor, captured on the accepted start.
- `busy`  out  1: high while state ≠ IDLE.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH: quotient (DIV/DIVU) or remainder (REM/REMU); held until the next `done`.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, start = 1:**
  - Latch op and sign flags. Sign flags apply to signed ops only: sa = a[MSB], sb = b[MSB].
  - Latch |a| and |b|. For unsigned ops, use raw values.
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter.
  - Go to CALC.
- **Special cases, checked on the accepted start; go straight back to IDLE with done = 1:**
  - b == 0: quotient = all ones; remainder = a (raw).
  - Signed op, a == 100…0 and b == all ones: quotient = a; remainder = 0.
- **CALC, one iteration per cycle for WIDTH cycles:**
  - Shift: rem ← {rem[WIDTH-1:0], dividend MSB}; dividend shifts left.
  - Compute diff = rem − {0, divisor} with the `add_and_subtract` instance.
  - If no borrow (cout = 1): rem ← diff and quotient LSB ← 1. Otherwise rem is unchanged and quotient LSB ← 0.
  - After iteration WIDTH−1, go to FIX.
- **FIX:**
  - Signed quotient is negated if sa ^ sb.
  - Signed remainder is negated if sa.
  - Select the output per op, register it to `result`, pulse `done`, return to IDLE.
- **Operand capture:** `start` while busy is ignored. Changes on `a`, `b` or `op` after acceptance have no effect.
- **Arithmetic:** negation is two's complement, WIDTH bits, wrap-around allowed. Remainder sign always follows the dividend, so a == 0 gives result 0 with no negative zero.

## Timing
- **Reset values:** state = IDLE, busy = 0, done = 0, result = 0.
- **Reset mid-operation:** abort; no done pulse; result = 0 on the next cycle.
- **Normal latency:** start sampled at edge N → busy = 1 after edge N, done = 1 and result valid in the cycle after edge N+WIDTH+1, busy = 0 in that same cycle. Total: WIDTH+1 busy cycles, done on the (WIDTH+2)th cycle after start.
- **Special-case latency:** done = 1 and result valid in the cycle after edge N; busy never asserts.
- **Back-to-back:** start high while done = 1 is accepted, since state is IDLE. The next done has no gap other than the computation latency.
- **done width:** exactly one cycle.
- **result stability:** changes only on edges that set done, or on reset.
- **Simultaneous start and rst:** rst wins.

## Test plan
- **DIVU:** a = 100, b = 7, start one cycle → done exactly 33 cycles after the start edge, result = 14, busy high for 33 cycles. Repeat with REMU → result = 2.
- **Signed DIV/REM:**
  - a = −7 (0xFFFFFFF9), b = 2: DIV → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1).
  - a = 7, b = −2: DIV → −3; REM → 1.
- **Divide by zero:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - REM 0x80000000/0 → 0x80000000.
  - Each: done in the cycle after start, busy never high.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; one-cycle latency. Also check DIVU of the same operands → 0 (normal 33-cycle path).
- **Busy and operand capture:** start DIVU 1000/10, then pulse start with other operands and toggle a/b during CALC → ignored; result = 100 at the normal time. Issue a new start in the done cycle → accepted, second result correct.
- **Reset mid-CALC:** assert rst at cycle 10 of a DIV → no done pulse ever, busy = 0 and result = 0 after the reset edge. A subsequent DIVU 9/3 → 3 with normal latency.
